// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues ROM reads at the PC address, buffers the
// returned words with their fetch address in a small FIFO and hands them to
// decode over valid/ready. Back-pressures the PC with hold; a taken jump
// (flush) drops everything queued or in flight.
module instr_fetch_queue #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_addr,
  output logic               hold,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               flush,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Queue storage: instruction word and the address it came from.
  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [ADDR_W-1:0]  pc_mem_q    [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  // Set for the single cycle following reset so no fetch is issued then.
  logic              post_reset_q;

  logic [CNT_W:0]    credits_used;
  logic              push;
  logic              pop;

  // Each queued word and each outstanding read consumes one slot; stall the
  // PC once all slots are spoken for so a returning word always fits.
  assign credits_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
  assign hold         = ~reset & (credits_used >= (CNT_W+1)'(DEPTH));

  assign mem_addr     = pc_addr;
  assign mem_rd       = ~hold & ~flush & ~reset & ~post_reset_q;

  assign instr_valid  = ~reset & (count_q != '0);
  assign instr_out    = instr_mem_q[rd_ptr_q];
  assign instr_pc     = pc_mem_q[rd_ptr_q];

  // A word returning while a jump is taken belongs to the old stream.
  assign push = inflight_q & ~flush;
  assign pop  = instr_valid & instr_ready & ~flush;

  // Next-state for pointers, occupancy and the in-flight tracker.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = mem_rd;
    inflight_pc_d = inflight_pc_q;
    if (mem_rd) begin
      inflight_pc_d = pc_addr;
    end
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      inflight_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      post_reset_q  <= 1'b1;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      post_reset_q  <= 1'b0;
    end
  end

  // Capture the returning ROM word into the tail slot.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      instr_mem_q[wr_ptr_q] <= mem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  // The credit scheme must never let a word arrive at a full queue.
  assert property (@(posedge clk) disable iff (reset)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed testbench for instr_fetch_queue: models the PC (advances after
// each issued fetch) and a ROM with ROM[a] = a + 0x100.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pc_addr;
  logic        hold;
  logic [7:0]  mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        flush;
  logic [15:0] instr_out;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_checks = 0;
  int n_fail   = 0;
  int nrd;

  always #5 clk = ~clk;

  // Synchronous ROM: data for the address presented at an edge appears after it.
  always @(posedge clk) mem_rdata <= {8'h01, mem_addr};

  instr_fetch_queue #(.ADDR_W(8), .INSTR_W(16), .DEPTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_addr     (pc_addr),
    .hold        (hold),
    .mem_addr    (mem_addr),
    .mem_rd      (mem_rd),
    .mem_rdata   (mem_rdata),
    .flush       (flush),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: the PC advances only if a fetch was issued this cycle.
  task automatic cyc();
    logic rd;
    rd = mem_rd;
    @(posedge clk);
    #1;
    if (rd) pc_addr = pc_addr + 8'd1;
  endtask

  task automatic check_head(input string tag, input logic [7:0] exp_pc);
    check_eq({tag, "_valid"}, instr_valid, 1'b1);
    check_eq({tag, "_pc"}, instr_pc, exp_pc);
    check_eq({tag, "_instr"}, instr_out, {8'h01, exp_pc});
    $display("%s: head pc=0x%02h instr=0x%04h ready=%0b", tag, instr_pc, instr_out, instr_ready);
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_valid"}, instr_valid, 1'b0);
    check_eq({tag, "_hold"}, hold, 1'b0);
    check_eq({tag, "_rd"}, mem_rd, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; instr_ready = 1'b0; pc_addr = 8'h00;
    #1; check_quiet("rst_active");
    cyc();
    cyc();
    reset = 1'b0;
    #1; check_quiet("rst_after");
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;

    // 1: streaming with ready=1, first word two cycles after first fetch
    do_reset();
    instr_ready = 1'b1;
    #1;
    check_eq("t1_rd0", mem_rd, 1'b1);
    check_eq("t1_addr0", mem_addr, 8'h00);
    check_eq("t1_v0", instr_valid, 1'b0);
    cyc();
    #1; check_eq("t1_v1", instr_valid, 1'b0);
    cyc();
    for (int k = 0; k < 6; k++) begin
      #1; check_head("t1_stream", 8'(k));
      cyc();
    end

    // 2: ready=0 fills exactly DEPTH entries, then one pop frees one credit
    do_reset();
    nrd = 0;
    for (int k = 0; k < 8; k++) begin
      #1; nrd += int'(mem_rd);
      cyc();
    end
    check_eq("t2_fetches", nrd, 4);
    #1;
    check_eq("t2_hold", hold, 1'b1);
    check_eq("t2_rd_stalled", mem_rd, 1'b0);
    check_head("t2_head", 8'h00);
    instr_ready = 1'b1;
    #1; check_eq("t2_pop_hold", hold, 1'b1);
    cyc();
    instr_ready = 1'b0;
    #1;
    check_eq("t2_hold_drop", hold, 1'b0);
    check_eq("t2_rd_resume", mem_rd, 1'b1);
    check_eq("t2_addr4", mem_addr, 8'h04);
    check_head("t2_head1", 8'h01);
    cyc();
    #1;
    check_eq("t2_hold_again", hold, 1'b1);

    // 3: flush with 3 queued + 1 in flight, restart at 0x40
    flush = 1'b1;
    #1; check_eq("t3_flush_rd", mem_rd, 1'b0);
    cyc();
    flush = 1'b0; pc_addr = 8'h40; instr_ready = 1'b1;
    #1;
    check_eq("t3_valid0", instr_valid, 1'b0);
    check_eq("t3_hold0", hold, 1'b0);
    check_eq("t3_rd", mem_rd, 1'b1);
    check_eq("t3_addr", mem_addr, 8'h40);
    cyc();
    #1; check_eq("t3_valid1", instr_valid, 1'b0);
    cyc();
    #1; check_head("t3_new0", 8'h40);
    cyc();
    #1; check_head("t3_new1", 8'h41);
    cyc();

    // 4: push+pop at count 2, order preserved across pointer wrap
    do_reset();
    cyc();
    cyc();
    cyc();
    instr_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check_head("t4_stream", 8'(k));
      check_eq("t4_hold", hold, 1'b0);
      cyc();
    end
    instr_ready = 1'b0;
    nrd = 0;
    for (int k = 0; k < 6; k++) begin
      #1; nrd += int'(mem_rd);
      cyc();
    end
    check_eq("t4_extra_fetch", nrd, 1);
    #1;
    check_eq("t4_full_hold", hold, 1'b1);
    check_head("t4_after", 8'd12);

    // 5: reset mid-stream with a full queue, clean restart at pc 0
    reset = 1'b1;
    #1; check_quiet("t5_rst");
    cyc();
    reset = 1'b0; pc_addr = 8'h00; instr_ready = 1'b1;
    #1; check_quiet("t5_post");
    cyc();
    #1;
    check_eq("t5_rd", mem_rd, 1'b1);
    check_eq("t5_addr", mem_addr, 8'h00);
    cyc();
    #1; check_eq("t5_valid1", instr_valid, 1'b0);
    cyc();
    #1; check_head("t5_restart", 8'h00);
    cyc();

    // 6: flush while full
    instr_ready = 1'b0;
    for (int k = 0; k < 6; k++) cyc();
    #1;
    check_eq("t6_full_hold", hold, 1'b1);
    flush = 1'b1;
    #1;
    check_eq("t6_flush_rd", mem_rd, 1'b0);
    check_eq("t6_flush_hold", hold, 1'b1);
    cyc();
    flush = 1'b0; pc_addr = 8'h80; instr_ready = 1'b1;
    #1;
    check_eq("t6_hold0", hold, 1'b0);
    check_eq("t6_valid0", instr_valid, 1'b0);
    check_eq("t6_rd", mem_rd, 1'b1);
    check_eq("t6_addr", mem_addr, 8'h80);
    cyc();
    #1; check_eq("t6_valid1", instr_valid, 1'b0);
    cyc();
    #1; check_head("t6_new", 8'h80);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
